dispatch_scoreboard: RTL and testbench

//  Consumer end of the schedule-stage interface. Takes the registered SCHEDULE_* instruction plus its sources,

---
 rtl/dispatch_scoreboard.sv | 122 ++++++++++++
 tb/tb_dispatch_scoreboard.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_scoreboard.sv
// Dispatch stage with a register scoreboard: stalls on RAW/WAW hazards and when too many writes are in flight.
// Optional SB_ERR sticky error flag is enabled by defining SCOREBOARD_ERR_EN.
module dispatch_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        MEM_WAIT,
  input  logic [31:0] SCHEDULE_PC,
  input  logic [16:0] SCHEDULE_OPCODE,
  input  logic [4:0]  SCHEDULE_RD,
  input  logic [4:0]  SCHEDULE_RS1,
  input  logic [4:0]  SCHEDULE_RS2,
  input  logic [11:0] SCHEDULE_CSR,
  input  logic [31:0] SCHEDULE_IMM,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_RD,
`ifdef SCOREBOARD_ERR_EN
  output logic        SB_ERR,
`endif
  output logic        STALL,
  output logic        DISPATCH_VALID,
  output logic [31:0] DISPATCH_PC,
  output logic [16:0] DISPATCH_OPCODE,
  output logic [4:0]  DISPATCH_RD,
  output logic [11:0] DISPATCH_CSR,
  output logic [31:0] DISPATCH_IMM
);

  logic [31:0]      pending;
  logic [31:0]      pending_nxt;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_nxt;

  logic valid;
  logic rd_nz;
  logic full;
  logic hazard;
  logic dispatch;
  logic sb_set;
  logic wb_clr;

  assign valid    = (SCHEDULE_OPCODE != 17'd0);
  assign rd_nz    = (SCHEDULE_RD != 5'd0);
  assign full     = (inflight == CNT_W'(MAX_INFLIGHT));
  assign hazard   = valid & (pending[SCHEDULE_RS1] | pending[SCHEDULE_RS2] |
                             (rd_nz & pending[SCHEDULE_RD]) | (rd_nz & full));
  assign STALL    = hazard & ~FLUSH & ~MEM_WAIT;
  assign dispatch = valid & ~hazard & ~FLUSH & ~MEM_WAIT;
  assign sb_set   = dispatch & rd_nz;
  // Only a write that is actually outstanding may retire; anything else is spurious.
  assign wb_clr   = WB_VALID & (WB_RD != 5'd0) & pending[WB_RD];

  always_comb begin
    pending_nxt = pending;
    if (wb_clr) pending_nxt[WB_RD] = 1'b0;
    if (sb_set) pending_nxt[SCHEDULE_RD] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    inflight_nxt = inflight;
    case ({sb_set, wb_clr})
      2'b10:   inflight_nxt = inflight + CNT_W'(1);
      2'b01:   inflight_nxt = inflight - CNT_W'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending  <= '0;
      inflight <= '0;
    end else begin
      pending  <= pending_nxt;
      inflight <= inflight_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      DISPATCH_VALID  <= 1'b0;
      DISPATCH_PC     <= '0;
      DISPATCH_OPCODE <= '0;
      DISPATCH_RD     <= '0;
      DISPATCH_CSR    <= '0;
      DISPATCH_IMM    <= '0;
    end else if (MEM_WAIT) begin
      DISPATCH_VALID  <= DISPATCH_VALID;
    end else if (dispatch) begin
      DISPATCH_VALID  <= 1'b1;
      DISPATCH_PC     <= SCHEDULE_PC;
      DISPATCH_OPCODE <= SCHEDULE_OPCODE;
      DISPATCH_RD     <= SCHEDULE_RD;
      DISPATCH_CSR    <= SCHEDULE_CSR;
      DISPATCH_IMM    <= SCHEDULE_IMM;
    end else begin
      DISPATCH_VALID  <= 1'b0;
      DISPATCH_PC     <= '0;
      DISPATCH_OPCODE <= '0;
      DISPATCH_RD     <= '0;
      DISPATCH_CSR    <= '0;
      DISPATCH_IMM    <= '0;
    end
  end

`ifdef SCOREBOARD_ERR_EN
  logic spurious_wb;
  logic overflow;

  assign spurious_wb = WB_VALID & (WB_RD != 5'd0) & ~pending[WB_RD];
  assign overflow    = sb_set & ~wb_clr & full;

  always_ff @(posedge CLK) begin
    if (RST)                         SB_ERR <= 1'b0;
    else if (spurious_wb | overflow) SB_ERR <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dispatch_scoreboard.sv
// Directed self-checking bench for dispatch_scoreboard (default MAX_INFLIGHT=4).
// Define SCOREBOARD_ERR_EN to also exercise the SB_ERR flag.
module tb_dispatch_scoreboard;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        MEM_WAIT;
  logic [31:0] SCHEDULE_PC;
  logic [16:0] SCHEDULE_OPCODE;
  logic [4:0]  SCHEDULE_RD;
  logic [4:0]  SCHEDULE_RS1;
  logic [4:0]  SCHEDULE_RS2;
  logic [11:0] SCHEDULE_CSR;
  logic [31:0] SCHEDULE_IMM;
  logic        WB_VALID;
  logic [4:0]  WB_RD;
  logic        STALL;
  logic        DISPATCH_VALID;
  logic [31:0] DISPATCH_PC;
  logic [16:0] DISPATCH_OPCODE;
  logic [4:0]  DISPATCH_RD;
  logic [11:0] DISPATCH_CSR;
  logic [31:0] DISPATCH_IMM;
`ifdef SCOREBOARD_ERR_EN
  logic        SB_ERR;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 CLK = ~CLK;

  dispatch_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
    .SCHEDULE_PC(SCHEDULE_PC), .SCHEDULE_OPCODE(SCHEDULE_OPCODE),
    .SCHEDULE_RD(SCHEDULE_RD), .SCHEDULE_RS1(SCHEDULE_RS1), .SCHEDULE_RS2(SCHEDULE_RS2),
    .SCHEDULE_CSR(SCHEDULE_CSR), .SCHEDULE_IMM(SCHEDULE_IMM),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD),
`ifdef SCOREBOARD_ERR_EN
    .SB_ERR(SB_ERR),
`endif
    .STALL(STALL), .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_PC(DISPATCH_PC),
    .DISPATCH_OPCODE(DISPATCH_OPCODE), .DISPATCH_RD(DISPATCH_RD),
    .DISPATCH_CSR(DISPATCH_CSR), .DISPATCH_IMM(DISPATCH_IMM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic instr(input logic [16:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] pc);
    SCHEDULE_OPCODE = op;
    SCHEDULE_RD     = rd;
    SCHEDULE_RS1    = rs1;
    SCHEDULE_RS2    = rs2;
    SCHEDULE_PC     = pc;
    SCHEDULE_CSR    = pc[11:0] ^ 12'h300;
    SCHEDULE_IMM    = ~pc;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    WB_VALID = v;
    WB_RD    = rd;
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; MEM_WAIT = 1'b0;
    instr(17'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    wb(1'b0, 5'd0);
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_valid", 32'(DISPATCH_VALID), 32'd0);
    chk("rst_stall", 32'(STALL), 32'd0);
    chk("rst_pc", DISPATCH_PC, 32'd0);
    chk("rst_inflight", 32'(dut.inflight), 32'd0);
`ifdef SCOREBOARD_ERR_EN
    chk("rst_sberr", 32'(SB_ERR), 32'd0);
`endif

    // First dispatch: RD=5
    instr(17'h00013, 5'd5, 5'd1, 5'd2, 32'h100);
    #1 chk("d1_stall", 32'(STALL), 32'd0);
    tick();
    chk("d1_valid", 32'(DISPATCH_VALID), 32'd1);
    chk("d1_rd", 32'(DISPATCH_RD), 32'd5);
    chk("d1_pc", DISPATCH_PC, 32'h100);
    chk("d1_op", 32'(DISPATCH_OPCODE), 32'h13);
    chk("d1_csr", 32'(DISPATCH_CSR), 32'h200);
    chk("d1_imm", DISPATCH_IMM, 32'hFFFF_FEFF);
    chk("d1_inflight", 32'(dut.inflight), 32'd1);

    // RAW on x5
    instr(17'h00033, 5'd7, 5'd5, 5'd0, 32'h104);
    #1 chk("raw_stall0", 32'(STALL), 32'd1);
    tick();
    chk("raw_valid0", 32'(DISPATCH_VALID), 32'd0);
    chk("raw_pc0", DISPATCH_PC, 32'd0);
    chk("raw_stall1", 32'(STALL), 32'd1);
    tick();
    chk("raw_valid1", 32'(DISPATCH_VALID), 32'd0);
    wb(1'b1, 5'd5);
    #1 chk("raw_stall_wbcycle", 32'(STALL), 32'd1);
    tick();
    wb(1'b0, 5'd0);
    #1 chk("raw_stall_after_wb", 32'(STALL), 32'd0);
    chk("raw_valid_after_wb", 32'(DISPATCH_VALID), 32'd0);
    chk("raw_inflight_after_wb", 32'(dut.inflight), 32'd0);
    tick();
    chk("raw_disp_valid", 32'(DISPATCH_VALID), 32'd1);
    chk("raw_disp_rd", 32'(DISPATCH_RD), 32'd7);
    chk("raw_disp_pc", DISPATCH_PC, 32'h104);
    chk("raw_inflight", 32'(dut.inflight), 32'd1);

    instr(17'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    wb(1'b1, 5'd7);
    tick();
    wb(1'b0, 5'd0);
    chk("bubble_valid", 32'(DISPATCH_VALID), 32'd0);
    chk("clr7_inflight", 32'(dut.inflight), 32'd0);

    // Fill to MAX_INFLIGHT with RD=1..4
    for (int i = 1; i <= 4; i++) begin
      instr(17'h00013, 5'(i), 5'd0, 5'd0, 32'h300 + 32'(4 * i));
      #1 chk("fill_stall", 32'(STALL), 32'd0);
      tick();
      chk("fill_rd", 32'(DISPATCH_RD), 32'(i));
    end
    chk("full_inflight", 32'(dut.inflight), 32'd4);
    instr(17'h00013, 5'd6, 5'd0, 5'd0, 32'h400);
    #1 chk("full_stall", 32'(STALL), 32'd1);
    tick();
    chk("full_valid", 32'(DISPATCH_VALID), 32'd0);
    wb(1'b1, 5'd2);
    #1 chk("full_stall_wbcycle", 32'(STALL), 32'd1);
    tick();
    wb(1'b0, 5'd0);
    #1 chk("full_stall_after_wb", 32'(STALL), 32'd0);
    chk("full_inflight_after_wb", 32'(dut.inflight), 32'd3);
    tick();
    chk("full_disp_rd", 32'(DISPATCH_RD), 32'd6);
    chk("full_disp_inflight", 32'(dut.inflight), 32'd4);

    // RD=0 dispatch while full plus WB x1 -> 3 left: {3,4,6}
    instr(17'h00013, 5'd0, 5'd0, 5'd0, 32'h500);
    wb(1'b1, 5'd1);
    #1 chk("rd0_full_stall", 32'(STALL), 32'd0);
    tick();
    chk("rd0_full_valid", 32'(DISPATCH_VALID), 32'd1);
    chk("rd0_full_inflight", 32'(dut.inflight), 32'd3);
    // Simultaneous dispatch RD=8 and WB x3 -> {4,6,8}
    instr(17'h00013, 5'd8, 5'd0, 5'd0, 32'h504);
    wb(1'b1, 5'd3);
    tick();
    chk("simul_rd", 32'(DISPATCH_RD), 32'd8);
    chk("simul_inflight", 32'(dut.inflight), 32'd3);
    // Spurious WB to x3 and WB to x0 are ignored
    instr(17'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    wb(1'b1, 5'd3);
    tick();
    chk("spur_inflight", 32'(dut.inflight), 32'd3);
`ifdef SCOREBOARD_ERR_EN
    chk("spur_sberr", 32'(SB_ERR), 32'd1);
`endif
    wb(1'b1, 5'd0);
    tick();
    wb(1'b0, 5'd0);
    chk("wb0_inflight", 32'(dut.inflight), 32'd3);

    // 10 back-to-back RD=0 instructions
    for (int i = 0; i < 10; i++) begin
      instr(17'h00013, 5'd0, 5'd0, 5'd0, 32'h600 + 32'(4 * i));
      #1 chk("b2b_stall", 32'(STALL), 32'd0);
      tick();
      chk("b2b_valid", 32'(DISPATCH_VALID), 32'd1);
      chk("b2b_pc", DISPATCH_PC, 32'h600 + 32'(4 * i));
    end
    chk("b2b_inflight", 32'(dut.inflight), 32'd3);

    // FLUSH while stalled on x4
    instr(17'h00033, 5'd9, 5'd4, 5'd0, 32'h700);
    #1 chk("fl_stall_pre", 32'(STALL), 32'd1);
    FLUSH = 1'b1;
    #1 chk("fl_stall", 32'(STALL), 32'd0);
    tick();
    FLUSH = 1'b0;
    chk("fl_valid", 32'(DISPATCH_VALID), 32'd0);
    #1 chk("fl_stall_post", 32'(STALL), 32'd1);
    chk("fl_inflight", 32'(dut.inflight), 32'd3);

    // Retire x4, dispatch RD=10 -> {6,8,10}
    instr(17'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    wb(1'b1, 5'd4);
    tick();
    wb(1'b0, 5'd0);
    instr(17'h00033, 5'd10, 5'd4, 5'd0, 32'h200);
    tick();
    chk("mw_pre_valid", 32'(DISPATCH_VALID), 32'd1);
    chk("mw_pre_inflight", 32'(dut.inflight), 32'd3);

    // MEM_WAIT for 3 cycles with a WB in the first
    instr(17'h00013, 5'd11, 5'd0, 5'd0, 32'h204);
    MEM_WAIT = 1'b1;
    wb(1'b1, 5'd6);
    #1 chk("mw_stall", 32'(STALL), 32'd0);
    tick();
    wb(1'b0, 5'd0);
    chk("mw_inflight", 32'(dut.inflight), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("mw_hold_valid", 32'(DISPATCH_VALID), 32'd1);
      chk("mw_hold_pc", DISPATCH_PC, 32'h200);
      chk("mw_hold_rd", 32'(DISPATCH_RD), 32'd10);
      if (i < 2) tick();
    end
    MEM_WAIT = 1'b0;
    tick();
    chk("mw_release_pc", DISPATCH_PC, 32'h204);
    chk("mw_release_rd", 32'(DISPATCH_RD), 32'd11);
    chk("mw_release_inflight", 32'(dut.inflight), 32'd3);

    // Reset mid-operation; later WB to x8 is spurious
    RST = 1'b1;
    instr(17'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    RST = 1'b0;
    chk("mrst_valid", 32'(DISPATCH_VALID), 32'd0);
    chk("mrst_pc", DISPATCH_PC, 32'd0);
    chk("mrst_inflight", 32'(dut.inflight), 32'd0);
`ifdef SCOREBOARD_ERR_EN
    chk("mrst_sberr", 32'(SB_ERR), 32'd0);
    wb(1'b1, 5'd0);
    tick();
    chk("wb0_sberr", 32'(SB_ERR), 32'd0);
`endif
    wb(1'b1, 5'd8);
    tick();
    wb(1'b0, 5'd0);
    chk("mrst_spur_inflight", 32'(dut.inflight), 32'd0);
    instr(17'h00013, 5'd12, 5'd8, 5'd10, 32'h800);
    #1 chk("mrst_stall", 32'(STALL), 32'd0);
    tick();
    chk("mrst_disp_rd", 32'(DISPATCH_RD), 32'd12);
    chk("mrst_disp_inflight", 32'(dut.inflight), 32'd1);
`ifdef SCOREBOARD_ERR_EN
    chk("sticky_sberr", 32'(SB_ERR), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
